// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - opcode classes, FSM state encoding and class decode for wb_stage
package wb_pkg;

   localparam int unsigned OPC_LW     = 0;
   localparam int unsigned OPC_SW     = 1;
   localparam int unsigned OPC_ALU_LO = 2;
   localparam int unsigned OPC_ALU_HI = 18;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } wb_state_e;

   typedef enum logic [1:0] {
      CLS_LOAD  = 2'd0,
      CLS_STORE = 2'd1,
      CLS_ALU   = 2'd2,
      CLS_NOP   = 2'd3
   } opc_class_e;

   // Everything above the ALU range (and any opcode not otherwise claimed) is a NOP.
   function automatic opc_class_e decode_class(input int unsigned opc);
      if (opc == OPC_LW) begin
         return CLS_LOAD;
      end else if (opc == OPC_SW) begin
         return CLS_STORE;
      end else if (opc >= OPC_ALU_LO && opc <= OPC_ALU_HI) begin
         return CLS_ALU;
      end else begin
         return CLS_NOP;
      end
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - load-wait cycle counter with clear, enable and expiry flag
module wb_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   // Counts 0..TIMEOUT-1; expiry marks the last permitted wait cycle.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

   // Next count: clear wins, and the counter parks at expiry instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered write-back stage; WB_FWD_EN adds the execute-stage forwarding port
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned OPC_MSB = 31,
   parameter int unsigned OPC_W   = 5,
   parameter int unsigned RD_LSB  = 22,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [CNT_W-1:0]  retired,
   output logic              err_timeout
`ifdef WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   wb_state_e         state_q;
   logic              rf_we_q;
   logic [REG_AW-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  retired_q;
   logic              err_q;

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] rd;
   opc_class_e        cls;
   logic              accept;
   logic              tmo_expired;
   logic              unused_instr;

   assign opc          = instruction[OPC_MSB -: OPC_W];
   assign rd           = instruction[RD_LSB +: REG_AW];
   assign cls          = decode_class(32'(opc));
   assign unused_instr = ^instruction;

   // Only a pending load blocks the stage.
   assign in_ready = (state_q != ST_WAIT_MEM);
   assign accept   = in_valid & in_ready;

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_q != ST_WAIT_MEM),
      .en_i      ((state_q == ST_WAIT_MEM) & ~mem_rsp_valid),
      .expired_o (tmo_expired)
   );

   // Write-back FSM: the write pulse and retire count are registered together on the
   // edge that enters COMMIT, so rf_we and the new count appear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rf_we_q   <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         retired_q <= '0;
         err_q     <= 1'b0;
      end else begin
         rf_we_q <= 1'b0;
         case (state_q)
            ST_WAIT_MEM: begin
               if (mem_rsp_valid) begin
                  wdata_q   <= mem_rsp_data;
                  rf_we_q   <= (waddr_q != '0);
                  retired_q <= retired_q + 1'b1;
                  state_q   <= ST_COMMIT;
               end else if (tmo_expired) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               // IDLE and COMMIT accept identically, giving back-to-back ALU retire.
               state_q <= ST_IDLE;
               if (accept) begin
                  case (cls)
                     CLS_LOAD: begin
                        waddr_q <= rd;
                        state_q <= ST_WAIT_MEM;
                     end
                     CLS_ALU: begin
                        waddr_q   <= rd;
                        wdata_q   <= alu_data;
                        rf_we_q   <= (rd != '0);
                        retired_q <= retired_q + 1'b1;
                        state_q   <= ST_COMMIT;
                     end
                     default: begin
                        retired_q <= retired_q + 1'b1;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign rf_we       = rf_we_q;
   assign rf_waddr    = waddr_q;
   assign rf_wdata    = wdata_q;
   assign retired     = retired_q;
   assign err_timeout = err_q;

`ifdef WB_FWD_EN
   assign fwd_valid = rf_we_q & (waddr_q != '0);
   assign fwd_addr  = waddr_q;
   assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: vector table, directed corner cases, random vs model
module tb_wb_stage;

   localparam int TO = 4;
   localparam int CW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] alu_data;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [CW-1:0] retired;
   logic        err_timeout;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
`endif

   int checks = 0;
   int failures = 0;

   wb_stage #(
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .instruction   (instruction),
      .alu_data      (alu_data),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .retired       (retired),
      .err_timeout   (err_timeout)
`ifdef WB_FWD_EN
      ,
      .fwd_valid     (fwd_valid),
      .fwd_addr      (fwd_addr),
      .fwd_data      (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  opc;
      logic [4:0]  rd;
      logic [31:0] alu;
      bit          exp_we;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[$];

   // Transaction-level reference state.
   bit          m_wait;
   int          m_waited;
   int          m_rd;
   bit          m_we;
   int          m_waddr;
   logic [31:0] m_wdata;
   int          m_ret;
   bit          m_err;
   logic [4:0]  r_opc;
   logic [4:0]  r_rd;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_instr(input logic [4:0] opc, input logic [4:0] rd);
      instruction = {opc, rd, 22'($urandom)};
   endtask

   // One clock edge of the architectural rules: classes by opcode value,
   // loads wait up to TO cycles, rd 0 never writes, every completion retires.
   task automatic model_edge();
      m_we = 1'b0;
      if (m_wait) begin
         if (mem_rsp_valid) begin
            m_wait = 1'b0;
            m_ret  = (m_ret + 1) % (1 << CW);
            if (m_rd != 0) begin
               m_we    = 1'b1;
               m_waddr = m_rd;
               m_wdata = mem_rsp_data;
            end
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               m_wait = 1'b0;
               m_err  = 1'b1;
            end
         end
      end else if (in_valid) begin
         if (r_opc == 0) begin
            m_wait   = 1'b1;
            m_waited = 0;
            m_rd     = r_rd;
         end else begin
            m_ret = (m_ret + 1) % (1 << CW);
            if (r_opc >= 2 && r_opc <= 18 && r_rd != 0) begin
               m_we    = 1'b1;
               m_waddr = r_rd;
               m_wdata = alu_data;
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      instruction = '0;
      alu_data = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      repeat (2) cyc();
      chk("rst_rf_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_retired", retired, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      cyc();

      // Vector table: ALU sweep, store/NOP, rd 0 interleaved, all back-to-back.
      for (int op = 2; op <= 18; op++) begin
         vec_t v;
         v.opc = 5'(op); v.rd = 5'd5; v.alu = $urandom;
         v.exp_we = 1'b1; v.exp_waddr = 5'd5; v.exp_wdata = v.alu;
         vecs.push_back(v);
      end
      vecs.push_back('{5'd1,  5'd9,  32'h1111_2222, 1'b0, 5'd0,  32'h0});
      vecs.push_back('{5'd31, 5'd9,  32'h3333_4444, 1'b0, 5'd0,  32'h0});
      vecs.push_back('{5'd3,  5'd0,  32'hDEAD_0001, 1'b0, 5'd0,  32'h0});
      vecs.push_back('{5'd4,  5'd12, 32'hBEEF_0002, 1'b1, 5'd12, 32'hBEEF_0002});
      vecs.push_back('{5'd5,  5'd0,  32'hDEAD_0003, 1'b0, 5'd0,  32'h0});
      vecs.push_back('{5'd6,  5'd12, 32'hBEEF_0004, 1'b1, 5'd12, 32'hBEEF_0004});
      in_valid = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         set_instr(vecs[i].opc, vecs[i].rd);
         alu_data = vecs[i].alu;
         cyc();
         chk($sformatf("vec%0d_we", i), rf_we, vecs[i].exp_we);
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].exp_waddr);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
         end
         chk($sformatf("vec%0d_retired", i), retired, i + 1);
         chk($sformatf("vec%0d_ready", i), in_ready, 1);
      end
      in_valid = 1'b0;
      cyc();
      chk("pulse_end", rf_we, 0);

      // Load with a response three cycles after acceptance.
      set_instr(5'd0, 5'd7);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("ld_ready0", in_ready, 0);
      chk("ld_we0", rf_we, 0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("ld_ready_wait", in_ready, 0);
         chk("ld_we_wait", rf_we, 0);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'h8F38_FAAA;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("ld_we", rf_we, 1);
      chk("ld_waddr", rf_waddr, 7);
      chk("ld_wdata", rf_wdata, 32'h8F38_FAAA);
      chk("ld_retired", retired, 24);
      chk("ld_ready_commit", in_ready, 1);
      cyc();
      chk("ld_pulse_end", rf_we, 0);
      mem_rsp_valid = 1'b1;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("stray_rsp_we", rf_we, 0);
      chk("stray_rsp_retired", retired, 24);

      // Load that never gets a response.
      set_instr(5'd0, 5'd9);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      for (int k = 1; k < TO; k++) begin
         cyc();
         chk($sformatf("to_err_c%0d", k), err_timeout, 0);
         chk($sformatf("to_ready_c%0d", k), in_ready, 0);
      end
      cyc();
      chk("to_err", err_timeout, 1);
      chk("to_ready", in_ready, 1);
      chk("to_we", rf_we, 0);
      chk("to_retired", retired, 24);
      mem_rsp_valid = 1'b1;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("to_late_we", rf_we, 0);
      chk("to_err_sticky", err_timeout, 1);

      // Asynchronous reset while a load is pending.
      set_instr(5'd0, 5'd11);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_we", rf_we, 0);
      chk("mrst_waddr", rf_waddr, 0);
      chk("mrst_wdata", rf_wdata, 0);
      chk("mrst_retired", retired, 0);
      chk("mrst_err", err_timeout, 0);
      cyc();
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = $urandom;
      cyc();
      mem_rsp_valid = 1'b0;
      chk("mrst_late_we", rf_we, 0);
      chk("mrst_late_retired", retired, 0);
      chk("mrst_ready", in_ready, 1);

      // Retire counter wrap.
      set_instr(5'd31, 5'd3);
      in_valid = 1'b1;
      repeat ((1 << CW) - 1) cyc();
      chk("wrap_max", retired, (1 << CW) - 1);
      cyc();
      chk("wrap_zero", retired, 0);
      in_valid = 1'b0;
      cyc();

      // Random traffic against the reference model.
      m_wait = 1'b0; m_waited = 0; m_rd = 0; m_we = 1'b0;
      m_waddr = 0; m_wdata = '0; m_ret = 0; m_err = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0: r_opc = 5'd0;
            1: r_opc = 5'd1;
            2: r_opc = 5'($urandom_range(2, 18));
            default: r_opc = 5'($urandom_range(19, 31));
         endcase
         r_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         set_instr(r_opc, r_rd);
         alu_data = $urandom;
         mem_rsp_valid = ($urandom_range(0, 9) < 3);
         mem_rsp_data = $urandom;
         chk("rnd_ready", in_ready, !m_wait);
         @(posedge clk);
         model_edge();
         #1;
         chk("rnd_we", rf_we, m_we);
         if (m_we) begin
            chk("rnd_waddr", rf_waddr, m_waddr);
            chk("rnd_wdata", rf_wdata, m_wdata);
         end
         chk("rnd_retired", retired, m_ret);
         chk("rnd_err", err_timeout, m_err);
`ifdef WB_FWD_EN
         chk("rnd_fwd_valid", fwd_valid, m_we);
         if (m_we) begin
            chk("rnd_fwd_addr", fwd_addr, m_waddr);
            chk("rnd_fwd_data", fwd_data, m_wdata);
         end
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
